compare_crossing_detector: RTL
==============================

// Module: compare_crossing_detector
// PURPOSE
//  Consumes the lt/eq/gt status of a magnitude comparator (a = sample,
//  b = threshold) and reports debounced threshold crossings.
//  - Tracks whether the sample is above or below the threshold.
//  - Emits one-cycle rise/fall pulses when that state changes.
//  - Flags malformed status inputs.
//  Sits directly downstream of the comparator, in the clocked domain.
// PARAMETERS
//  DEBOUNCE   3  consecutive qualifying samples needed to change state (1..255)
//  CNT_WIDTH  8  width of the crossing event counter
// PORTS
//  clk          input   1          system clock, rising edge
//  reset        input   1          asynchronous, active-high reset
//  valid        input   1          lt/eq/gt are sampled only when 1
//  lt           input   1          comparator: a < b
//  eq           input   1          comparator: a == b
//  gt           input   1          comparator: a > b
//  above        output  1          debounced state: 1 = above threshold
//  rise         output  1          1-cycle pulse on BELOW->ABOVE commit
//  fall         output  1          1-cycle pulse on ABOVE->BELOW commit
//  err          output  1          sticky: malformed flag set seen
//  event_count  output  CNT_WIDTH  number of rise+fall events (see CONFIG)
// BEHAVIOUR
//  - Reset (async, immediate):
//    - state=BELOW; debounce cnt=0.
//    - above=rise=fall=err=0; event_count=0.
//  - A sample is well-formed when valid=1 and exactly one of lt/eq/gt is 1.
//  - Malformed valid sample (zero, two or three flags set):
//    - sets err on the next edge; err stays 1 until reset.
//    - state and cnt are unchanged.
//  - valid=0 or eq=1: state and cnt hold (neutral sample).
//  - FSM, all outputs registered:
//    - BELOW: gt -> CONFIRM_ABOVE with cnt=1. If DEBOUNCE==1, commit
//      directly to ABOVE instead. lt -> stay, cnt=0.
//    - CONFIRM_ABOVE: gt -> cnt+1. When cnt+1==DEBOUNCE, go to ABOVE and
//      set cnt=0. lt -> BELOW, cnt=0.
//    - ABOVE / CONFIRM_BELOW: mirror image, with lt and gt swapped.
//  - Commit timing: rise/fall and the new 'above' value appear on the clock
//    edge that samples the DEBOUNCE-th qualifying sample (visible the
//    following cycle).
//  - rise/fall are high for exactly one cycle and never high together.
//  - Back-to-back opposite crossings need at least DEBOUNCE samples each,
//    so consecutive pulses are at least DEBOUNCE cycles apart.
//  - cnt width is $clog2(DEBOUNCE+1); cnt never exceeds DEBOUNCE-1.
//  - Reset mid-confirm discards the partial count; no pulse is emitted.
// CONFIGURATION
//  CROSSING_EVENT_COUNT_EN
//  - Defined:
//    - event_count increments by 1 on every rise or fall commit.
//    - Wraps from 2**CNT_WIDTH-1 to 0.
//  - Undefined:
//    - Counter logic is not built; event_count is tied to 0.
//    - The port list is identical in both builds.
// TESTING
//  1. Assert reset for 1 cycle while in CONFIRM_ABOVE with cnt=2 -> all
//     outputs 0 at once; then 2x gt -> no rise (count restarts).
//  2. DEBOUNCE=3; gt valid for 3 cycles -> rise=1 for 1 cycle after the
//     3rd sample, above=1; event_count=1 (macro on).
//  3. Samples gt,gt,lt,gt,gt -> no rise, above stays 0; next gt -> rise.
//  4. Samples gt,eq,(valid=0),gt,gt -> rise after the 3rd gt, not earlier.
//  5. valid=1 with lt=1,gt=1 while ABOVE -> err=1 next cycle, above stays 1;
//     err stays 1 after 3x lt (fall occurs) until reset.
//  6. CNT_WIDTH=2, DEBOUNCE=1; 4 alternating crossings -> event_count
//     1,2,3,0. Without the macro, event_count is 0 throughout.

Source files
------------

// File: rtl/compare_crossing_detector.sv
// compare_crossing_detector
// Turns the lt/eq/gt status of a magnitude comparator (a = sample,
// b = threshold) into a debounced above/below state with one-cycle
// rise/fall pulses.
// - A malformed status (valid with zero, two or three flags set) raises a
//   sticky err flag and does not disturb the state or the debounce count.
// - Optional macro CROSSING_EVENT_COUNT_EN adds a wrapping rise+fall event
//   counter. Without the macro, event_count is tied to zero. The port list
//   is the same in both builds.
module compare_crossing_detector #(
  parameter int DEBOUNCE  = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 lt,
  input  logic                 eq,
  input  logic                 gt,
  output logic                 above,
  output logic                 rise,
  output logic                 fall,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] event_count
);

  // Wide enough to hold DEBOUNCE itself, so the "last sample" compare
  // cannot alias.
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_ZERO_C = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE_C  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST_C = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_BELOW      = 2'd0,
    ST_CONF_ABOVE = 2'd1,
    ST_ABOVE      = 2'd2,
    ST_CONF_BELOW = 2'd3
  } state_t;

  // Exactly one of three flags set: the xor is odd-count, and the
  // all-three case is removed explicitly.
  function automatic logic is_onehot3(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [CW-1:0]   cnt_inc_s;
  logic            above_r;
  logic            rise_r;
  logic            fall_r;
  logic            err_r;
  logic            rise_s;
  logic            fall_s;
  logic            err_s;
  logic            above_s;

  assign cnt_inc_s = cnt_r + CNT_ONE_C;

  // Next-state, debounce count and pulse decode for the crossing FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    err_s   = err_r;
    if (valid && !is_onehot3(lt, eq, gt)) begin
      // Malformed sample: flag it and leave state and count untouched.
      err_s = 1'b1;
    end else if (valid && !eq) begin
      // Well-formed and not eq: exactly one of lt/gt is set.
      case (state_r)
        ST_BELOW: begin
          if (gt) begin
            if (DEBOUNCE == 32'sd1) begin
              state_s = ST_ABOVE;
              cnt_s   = CNT_ZERO_C;
              rise_s  = 1'b1;
            end else begin
              state_s = ST_CONF_ABOVE;
              cnt_s   = CNT_ONE_C;
            end
          end else begin
            cnt_s = CNT_ZERO_C;
          end
        end
        ST_CONF_ABOVE: begin
          if (gt) begin
            if (cnt_inc_s == CNT_LAST_C) begin
              state_s = ST_ABOVE;
              cnt_s   = CNT_ZERO_C;
              rise_s  = 1'b1;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            state_s = ST_BELOW;
            cnt_s   = CNT_ZERO_C;
          end
        end
        ST_ABOVE: begin
          if (lt) begin
            if (DEBOUNCE == 32'sd1) begin
              state_s = ST_BELOW;
              cnt_s   = CNT_ZERO_C;
              fall_s  = 1'b1;
            end else begin
              state_s = ST_CONF_BELOW;
              cnt_s   = CNT_ONE_C;
            end
          end else begin
            cnt_s = CNT_ZERO_C;
          end
        end
        ST_CONF_BELOW: begin
          if (lt) begin
            if (cnt_inc_s == CNT_LAST_C) begin
              state_s = ST_BELOW;
              cnt_s   = CNT_ZERO_C;
              fall_s  = 1'b1;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            state_s = ST_ABOVE;
            cnt_s   = CNT_ZERO_C;
          end
        end
        default: begin
          state_s = ST_BELOW;
          cnt_s   = CNT_ZERO_C;
        end
      endcase
    end else begin
      // Neutral sample (valid low or eq): hold everything.
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  // The confirm-below state still counts as above: it has not committed yet.
  always_comb begin
    above_s = (state_s == ST_ABOVE) || (state_s == ST_CONF_BELOW);
  end

  // State, count and registered outputs. Reset drops a partial confirm
  // without emitting a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_BELOW;
      cnt_r   <= CNT_ZERO_C;
      above_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      above_r <= above_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      err_r   <= err_s;
    end
  end

  assign above = above_r;
  assign rise  = rise_r;
  assign fall  = fall_r;
  assign err   = err_r;

`ifdef CROSSING_EVENT_COUNT_EN
  logic [CNT_WIDTH-1:0] evt_cnt_r;

  // Count commits. The count updates on the same edge as the pulse and
  // wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (rise_s || fall_s) begin
      evt_cnt_r <= evt_cnt_r + CNT_WIDTH'(32'd1);
    end else begin
      evt_cnt_r <= evt_cnt_r;
    end
  end

  assign event_count = evt_cnt_r;
`else
  assign event_count = {CNT_WIDTH{1'b0}};
`endif

endmodule
